// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes,
// datapath mux select values and the control/opcode-class bundles.
package ctrl_defs;

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCS_PC4    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_ALU    = 2'b10;

  typedef struct packed {
    logic rtype, iarith, load, store, branch, jal, jalr, ecall, illegal;
  } op_class_t;

  // Field order matches the top-level output concatenation.
  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       is_halted;
  } ctl_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode to one-hot instruction class decode.
module opcode_class
  import ctrl_defs::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE:  cls.rtype   = 1'b1;
      OP_IARITH: cls.iarith  = 1'b1;
      OP_LOAD:   cls.load    = 1'b1;
      OP_STORE:  cls.store   = 1'b1;
      OP_BRANCH: cls.branch  = 1'b1;
      OP_JAL:    cls.jal     = 1'b1;
      OP_JALR:   cls.jalr    = 1'b1;
      OP_ECALL:  cls.ecall   = 1'b1;
      default:   cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT) driving datapath selects.
// Define MEM_WAIT_EN to make IF and MEM stall on mem_ready.
module multicycle_ctrl
  import ctrl_defs::*;
#(
  parameter int STATE_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       ecall_halt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] wb_sel,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       is_halted
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               halted_q;
  logic               ready;
  op_class_t          cls;
  ctl_t               c;

`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  opcode_class u_cls (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STATE_W'(S_IF);
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == STATE_W'(S_HALT));
    end
  end

  always_comb begin
    state_d = STATE_W'(S_IF);
    case (state_q)
      STATE_W'(S_IF):  state_d = ready ? STATE_W'(S_ID) : STATE_W'(S_IF);
      STATE_W'(S_ID): begin
        if (cls.ecall && ecall_halt)      state_d = STATE_W'(S_HALT);
        else if (cls.ecall || cls.illegal) state_d = STATE_W'(S_IF);
        else                               state_d = STATE_W'(S_EX);
      end
      STATE_W'(S_EX): begin
        if (cls.rtype || cls.iarith)    state_d = STATE_W'(S_WB);
        else if (cls.load || cls.store) state_d = STATE_W'(S_MEM);
        else                            state_d = STATE_W'(S_IF);
      end
      STATE_W'(S_MEM): begin
        if (!ready)        state_d = STATE_W'(S_MEM);
        else if (cls.load) state_d = STATE_W'(S_WB);
        else               state_d = STATE_W'(S_IF);
      end
      STATE_W'(S_WB):   state_d = STATE_W'(S_IF);
      STATE_W'(S_HALT): state_d = STATE_W'(S_HALT);
      default:          state_d = STATE_W'(S_IF);
    endcase
  end

  always_comb begin
    c = '0;
    case (state_q)
      STATE_W'(S_IF): begin
        c.mem_read = 1'b1;
        c.ir_write = ready;
      end
      STATE_W'(S_ID): begin
        // ALUOut <- PC + imm, ready for a taken branch or JAL in EX
        c.alu_src_b = SRCB_IMM;
        if ((cls.ecall && !ecall_halt) || cls.illegal) begin
          c.pc_write  = 1'b1;
          c.pc_source = PCS_PC4;
        end
      end
      STATE_W'(S_EX): begin
        if (cls.rtype) begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_REG;
          c.alu_op    = ALU_FUNCT;
        end else if (cls.iarith) begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_FUNCT;
        end else if (cls.load || cls.store) begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
        end else if (cls.branch) begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_REG;
          c.alu_op    = ALU_BR;
          c.pc_write  = 1'b1;
          c.pc_source = alu_bcond ? PCS_ALUOUT : PCS_PC4;
        end else if (cls.jal) begin
          c.reg_write = 1'b1;
          c.wb_sel    = WB_PC4;
          c.pc_write  = 1'b1;
          c.pc_source = PCS_ALUOUT;
        end else if (cls.jalr) begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
          c.reg_write = 1'b1;
          c.wb_sel    = WB_PC4;
          c.pc_write  = 1'b1;
          c.pc_source = PCS_ALU;
        end
      end
      STATE_W'(S_MEM): begin
        c.i_or_d = 1'b1;
        if (cls.load) c.mem_read = 1'b1;
        if (cls.store) begin
          c.mem_write = 1'b1;
          c.pc_write  = ready;
          c.pc_source = PCS_PC4;
        end
      end
      STATE_W'(S_WB): begin
        c.reg_write = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_source = PCS_PC4;
        c.wb_sel    = cls.load ? WB_MDR : WB_ALU;
      end
      default: ;
    endcase
    c.is_halted = halted_q;
  end

  // Reset masks every output combinationally, aborting any in-flight access.
  assign {pc_write, i_or_d, mem_read, mem_write, ir_write, wb_sel, reg_write,
          alu_src_a, alu_src_b, alu_op, pc_source, is_halted} = reset ? '0 : c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level
// model built from per-class phase timelines.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       is_halted;
  } exp_t;

  typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_EC, K_BAD} kind_e;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond, ecall_halt, mem_ready;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, is_halted;
  logic [1:0] wb_sel, alu_src_b, alu_op, pc_source;
  exp_t       got;
  int         checks = 0;
  int         failures = 0;

  multicycle_ctrl #(.STATE_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
    .ecall_halt(ecall_halt), .mem_ready(mem_ready), .pc_write(pc_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .wb_sel(wb_sel), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  assign got = {pc_write, i_or_d, mem_read, mem_write, ir_write, wb_sel, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_source, is_halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1110011: return K_EC;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic string steps_of(input kind_e k, input logic hlt);
    case (k)
      K_R, K_I:            return "FDXW";
      K_LD:                return "FDXMW";
      K_ST:                return "FDXM";
      K_BR, K_JAL, K_JALR: return "FDX";
      K_EC:                return hlt ? "FDH" : "FD";
      default:             return "FD";
    endcase
  endfunction

  // Control lines expected in a given phase of an instruction's timeline.
  function automatic exp_t expect_ctl(input kind_e k, input byte s, input logic bc,
                                      input logic rdy, input logic hlt);
    exp_t e = '0;
    if (s == "F") begin
      e.mem_read = 1; e.ir_write = rdy;
    end else if (s == "D") begin
      e.alu_src_b = 2'b10;
      if ((k == K_EC && !hlt) || k == K_BAD) e.pc_write = 1;
    end else if (s == "X") begin
      case (k)
        K_R:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
        K_I:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; end
        K_LD, K_ST: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
        K_BR: begin
          e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write = 1;
          e.pc_source = bc ? 2'b01 : 2'b00;
        end
        K_JAL: begin e.reg_write = 1; e.wb_sel = 2'b10; e.pc_write = 1; e.pc_source = 2'b01; end
        K_JALR: begin
          e.alu_src_a = 1; e.alu_src_b = 2'b10; e.reg_write = 1; e.wb_sel = 2'b10;
          e.pc_write = 1; e.pc_source = 2'b10;
        end
        default: ;
      endcase
    end else if (s == "M") begin
      e.i_or_d = 1;
      if (k == K_LD) e.mem_read = 1;
      if (k == K_ST) begin e.mem_write = 1; e.pc_write = rdy; end
    end else if (s == "W") begin
      e.reg_write = 1; e.pc_write = 1; e.wb_sel = (k == K_LD) ? 2'b01 : 2'b00;
    end else if (s == "H") begin
      e.is_halted = 1;
    end
    return e;
  endfunction

  // bc<0: random branch outcome; mwaits<0: random mem_ready, else forced MEM waits.
  task automatic run_instr(input logic [6:0] opc, input logic hlt, input int bc,
                           input int mwaits, input bit abort_mem, output int ncyc);
    kind_e k = kind_of(opc);
    string steps = steps_of(k, hlt);
    int    pcw_cnt = 0;
    int    mlow = mwaits;
    logic  eff;
    bit    done;
    byte   s;
    ncyc = 0;
    for (int i = 0; i < steps.len(); i++) begin
      s = steps[i];
      done = 0;
      while (!done) begin
        opcode     = (s == "F") ? 7'($urandom) : opc;
        alu_bcond  = (bc < 0) ? 1'($urandom) : bc[0];
        ecall_halt = (k == K_EC) ? hlt : 1'($urandom);
        if (mwaits < 0) mem_ready = ($urandom_range(0, 3) != 0);
        else if (s == "M" && mlow > 0) begin mem_ready = 0; mlow--; end
        else mem_ready = 1;
`ifdef MEM_WAIT_EN
        eff = mem_ready;
`else
        eff = 1'b1;
`endif
        if (s == "M" && abort_mem) begin
          reset = 1;
          @(negedge clk);
          chk("abort_in_mem", 32'(got), 32'd0);
          @(posedge clk); #1;
          reset = 0;
          return;
        end
        @(negedge clk);
        chk($sformatf("op%02h_%c", opc, s), 32'(got), 32'(expect_ctl(k, s, alu_bcond, eff, hlt)));
        if (s == "H") return;
        ncyc++;
        pcw_cnt += int'(pc_write);
        done = (s == "F" || s == "M") ? eff : 1'b1;
        @(posedge clk); #1;
      end
    end
    chk($sformatf("op%02h_pcw_once", opc), 32'(pcw_cnt), 32'd1);
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b1110011, 7'b1111111, 7'b0001111};

  initial begin
    int n;
    reset = 1; opcode = '0; alu_bcond = 0; ecall_halt = 0; mem_ready = 0;
    repeat (2) begin
      opcode = 7'($urandom); alu_bcond = 1'($urandom);
      ecall_halt = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      chk("reset_out", 32'(got), 32'd0);
      @(posedge clk); #1;
    end
    reset = 0;

    run_instr(7'b0110011, 0, -1, 0, 0, n);
    chk("rtype_cycles", 32'(n), 32'd4);
`ifdef MEM_WAIT_EN
    run_instr(7'b0000011, 0, -1, 2, 0, n);
    chk("load_wait_cycles", 32'(n), 32'd7);
`else
    run_instr(7'b0000011, 0, -1, 2, 0, n);
    chk("load_wait_cycles", 32'(n), 32'd5);
`endif
    run_instr(7'b1100011, 0, 1, 0, 0, n);
    chk("br_taken_cycles", 32'(n), 32'd3);
    run_instr(7'b1100011, 0, 0, 0, 0, n);
    chk("br_ntaken_cycles", 32'(n), 32'd3);
    run_instr(7'b1110011, 0, -1, 0, 0, n);
    chk("ecall_cycles", 32'(n), 32'd2);
    run_instr(7'b0100011, 0, -1, 0, 0, n);
    chk("store_cycles", 32'(n), 32'd4);

    for (int t = 0; t < 80; t++) begin
      logic [6:0] op = ops[$urandom_range(0, 9)];
      run_instr(op, 0, -1, -1, 0, n);
    end

    run_instr(7'b0100011, 0, -1, 0, 1, n);
    run_instr(7'b0110011, 0, -1, 0, 0, n);
    chk("after_abort_cycles", 32'(n), 32'd4);

    run_instr(7'b1110011, 1, -1, 0, 0, n);
    @(posedge clk); #1;
    for (int t = 0; t < 12; t++) begin
      opcode = 7'($urandom); alu_bcond = 1'($urandom);
      ecall_halt = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      chk("halt_hold", 32'(got), 32'h1);
      @(posedge clk); #1;
    end
    reset = 1;
    @(negedge clk);
    chk("halt_reset", 32'(got), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    run_instr(7'b0110011, 0, -1, 0, 0, n);
    chk("post_halt_cycles", 32'(n), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
